alu_taylor_series: RTL and testbench

// - Parametrised Taylor-series evaluator, successor to the fixed 18-bit cosine calculator.
// - Evaluates sin, cos or exp of a signed fixed-point x with Horner's scheme on one internal multiplier.
// - Sits beside the synth ALU; the voice/LFO logic issues do_calc and consumes result on calc_done.

---
 rtl/alu_taylor_series.sv | 168 ++++++++++++++++
 tb/tb_alu_taylor_series.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_taylor_series.sv
// Horner-scheme Taylor evaluator for sin/cos/exp on a single registered multiplier.
// Optional saturation of intermediate results via `define ALU_TAYLOR_SAT_EN.
module alu_taylor_series #(
  parameter int unsigned DATA_W  = 18,
  parameter int unsigned FRAC_W  = 16,
  parameter int unsigned N_TERMS = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              do_calc,
  input  logic [1:0]        func_sel,
  input  logic [DATA_W-1:0] x_in,
  output logic              busy,
  output logic              calc_done,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  localparam int unsigned KW = $clog2(N_TERMS + 1);

  typedef logic [3:0][N_TERMS:0][DATA_W-1:0] rom_t;

  // c_k = d_k * round(2^FRAC_W / k!); row 3 stays all-zero.
  function automatic rom_t build_rom();
    rom_t   rom;
    longint fact;
    longint mag;
    longint d;
    rom = '0;
    for (int f = 0; f < 4; f++) begin
      fact = 1;
      for (int k = 0; k <= int'(N_TERMS); k++) begin
        if (k > 0) fact = fact * longint'(k);
        mag = ((longint'(1) << FRAC_W) + fact / 2) / fact;
        case (f)
          0:       d = (k % 4 == 1) ? 64'sd1 : ((k % 4 == 3) ? -64'sd1 : 64'sd0);
          1:       d = (k % 4 == 0) ? 64'sd1 : ((k % 4 == 2) ? -64'sd1 : 64'sd0);
          2:       d = 64'sd1;
          default: d = 64'sd0;
        endcase
        rom[2'(f)][KW'(k)] = DATA_W'(mag * d);
      end
    end
    return rom;
  endfunction

  localparam rom_t ROM = build_rom();

  localparam logic signed [2*DATA_W-1:0] PMAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] PMIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [2*DATA_W-1:0] RND_HALF = {{(2*DATA_W-1){1'b0}}, 1'b1} << (FRAC_W-1);
  localparam logic [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StLoad, StMul, StAdd, StDone} state_e;

  state_e state_q, state_d;

  logic [1:0]                func_q;
  logic signed [DATA_W-1:0]  x_q;
  logic signed [DATA_W-1:0]  acc_q;
  logic [KW-1:0]             k_q;
  logic signed [2*DATA_W-1:0] prod_q;
  logic                      ovf_int_q;
  logic [DATA_W-1:0]         result_q;
  logic                      ovf_q;
  logic                      done_q;

  logic signed [2*DATA_W-1:0] rnd_full;
  logic                       rnd_ovf;
  logic [DATA_W-1:0]          rnd_red;
  logic [KW-1:0]              k_m1;
  logic [DATA_W-1:0]          coef;
  logic [DATA_W:0]            sum;
  logic                       sum_ovf;
  logic [DATA_W-1:0]          sum_red;

  always_comb begin
    rnd_full = (prod_q + RND_HALF) >>> FRAC_W;
    rnd_ovf  = (rnd_full > PMAX) || (rnd_full < PMIN);
`ifdef ALU_TAYLOR_SAT_EN
    rnd_red  = rnd_ovf ? (rnd_full[2*DATA_W-1] ? DMIN : DMAX) : rnd_full[DATA_W-1:0];
`else
    rnd_red  = rnd_full[DATA_W-1:0];
`endif
    k_m1     = k_q - 1'b1;
    coef     = ROM[func_q][k_m1];
    // One guard bit: sign disagreement between the top two bits means out of range.
    sum      = {rnd_red[DATA_W-1], rnd_red} + {coef[DATA_W-1], coef};
    sum_ovf  = sum[DATA_W] ^ sum[DATA_W-1];
`ifdef ALU_TAYLOR_SAT_EN
    sum_red  = sum_ovf ? (sum[DATA_W] ? DMIN : DMAX) : sum[DATA_W-1:0];
`else
    sum_red  = sum[DATA_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (do_calc) state_d = StLoad;
      StLoad:  state_d = StMul;
      StMul:   state_d = StAdd;
      StAdd:   state_d = (k_q == KW'(1)) ? StDone : StMul;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      func_q    <= '0;
      x_q       <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      prod_q    <= '0;
      ovf_int_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (do_calc) begin
            func_q <= func_sel;
            x_q    <= x_in;
          end
        end
        StLoad: begin
          acc_q     <= ROM[func_q][N_TERMS];
          k_q       <= KW'(N_TERMS);
          ovf_int_q <= 1'b0;
        end
        StMul: begin
          prod_q <= (2*DATA_W)'(acc_q) * (2*DATA_W)'(x_q);
        end
        StAdd: begin
          acc_q     <= sum_red;
          k_q       <= k_m1;
          ovf_int_q <= ovf_int_q | rnd_ovf | sum_ovf;
        end
        StDone: begin
          result_q <= acc_q;
          ovf_q    <= ovf_int_q;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    calc_done = done_q;
    result    = result_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_alu_taylor_series.sv
// Scoreboard bench for alu_taylor_series: real-math reference, latency and request handling.
module tb_alu_taylor_series;

  logic        clk;
  logic        reset_n;
  logic        do_calc;
  logic [1:0]  func_sel;
  logic [17:0] x_in;
  logic        busy;
  logic        calc_done;
  logic [17:0] result;
  logic        ovf;

  alu_taylor_series dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .do_calc   (do_calc),
    .func_sel  (func_sel),
    .x_in      (x_in),
    .busy      (busy),
    .calc_done (calc_done),
    .result    (result),
    .ovf       (ovf)
  );

  typedef struct {
    int kind;   // 0: value within tol and ovf=0; 1: overflow expected
    int ev;
    int tol;
    int issue;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   busy_len = 0;
  int   done_count = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic int ref_val(input int f, input logic [17:0] x);
    real xr;
    real y;
    xr = $itor($signed(x)) / 65536.0;
    case (f)
      0:       y = $sin(xr);
      1:       y = $cos(xr);
      2:       y = $exp(xr);
      default: y = 0.0;
    endcase
    return $rtoi(y * 65536.0 + ((y >= 0.0) ? 0.5 : -0.5));
  endfunction

  // Monitor: pop and compare on each calc_done.
  initial forever begin
    exp_t e;
    int   diff;
    @(negedge clk);
    if (calc_done) begin
      done_count++;
      if (sbq.size() == 0) begin
        check("spurious_done", 1'b0, 1, 0);
      end else begin
        e = sbq.pop_front();
        check("latency", (cyc - e.issue) == 22, cyc - e.issue, 22);
        check("busy_len", busy_len == 22, busy_len, 22);
        if (e.kind == 0) begin
          diff = $signed(result) - e.ev;
          check("result", (diff <= e.tol) && (diff >= -e.tol), $signed(result), e.ev);
          check("ovf_clear", ovf == 1'b0, int'(ovf), 0);
        end else begin
          check("ovf_set", ovf == 1'b1, int'(ovf), 1);
`ifdef ALU_TAYLOR_SAT_EN
          check("sat_result", result == 18'h1FFFF, int'(result), 'h1FFFF);
`else
          check("wrap_result_not_sat", result != 18'h1FFFF, int'(result), 'h1FFFF);
`endif
        end
      end
    end
    if (busy) busy_len++;
    else busy_len = 0;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 200, n, 200);
  endtask

  task automatic issue(input int f, input logic [17:0] x, input int kind, input int ev,
                       input int tol, input bit push);
    exp_t e;
    wait_idle();
    func_sel = 2'(f);
    x_in     = x;
    do_calc  = 1'b1;
    e.kind   = kind;
    e.ev     = ev;
    e.tol    = tol;
    e.issue  = cyc + 1;
    if (push) sbq.push_back(e);
    @(negedge clk);
    do_calc = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", sbq.size() == 0, sbq.size(), 0);
  endtask

  initial begin
    exp_t        e;
    int          e0;
    int          base;
    int          f;
    int          xi;
    logic [17:0] xv;

    reset_n  = 1'b0;
    do_calc  = 1'b0;
    func_sel = 2'd0;
    x_in     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy == 1'b0, int'(busy), 0);
    check("rst_done", calc_done == 1'b0, int'(calc_done), 0);
    check("rst_result", result == 18'h0, int'(result), 0);
    check("rst_ovf", ovf == 1'b0, int'(ovf), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed values.
    issue(1, 18'h00000, 0, 65536, 1, 1'b1);
    issue(0, 18'h19220, 0, 65536, 8, 1'b1);
    issue(0, 18'h26DE0, 0, -65536, 8, 1'b1);
    issue(2, 18'h08000, 0, 'h1A613, 8, 1'b1);
    issue(2, 18'h30000, 0, 'h05E2D, 8, 1'b1);
    issue(2, 18'h10000, 1, 0, 0, 1'b1);
    issue(3, 18'h12345, 0, 0, 0, 1'b1);
    drain();

    // Randomised in-range arguments, back-to-back where the queue allows.
    for (int i = 0; i < 14; i++) begin
      f = int'($urandom_range(0, 3));
      case (f)
        0, 1:    xi = int'($urandom_range(0, 205888)) - 102944;
        2:       xi = int'($urandom_range(0, 104857)) - 65536;
        default: xi = int'($urandom_range(0, 262143));
      endcase
      xv = xi[17:0];
      issue(f, xv, 0, ref_val(f, xv), (f == 3) ? 0 : 8, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // do_calc held for 40 edges; inputs change after the first accept.
    wait_idle();
    base     = done_count;
    func_sel = 2'd1;
    x_in     = 18'h08000;
    do_calc  = 1'b1;
    e0       = cyc + 1;
    e.kind = 0; e.ev = ref_val(1, 18'h08000); e.tol = 8; e.issue = e0;
    sbq.push_back(e);
    @(negedge clk);
    func_sel = 2'd0;
    x_in     = 18'h3A000;
    e.kind = 0; e.ev = ref_val(0, 18'h3A000); e.tol = 8; e.issue = e0 + 23;
    sbq.push_back(e);
    repeat (39) @(negedge clk);
    do_calc = 1'b0;
    drain();
    repeat (30) @(negedge clk);
    check("hold_done_count", (done_count - base) == 2, done_count - base, 2);

    // Reset at edge 10 of a calculation aborts it.
    issue(0, 18'h0C000, 0, 0, 0, 1'b0);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy == 1'b0, int'(busy), 0);
    check("abort_result", result == 18'h0, int'(result), 0);
    check("abort_ovf", ovf == 1'b0, int'(ovf), 0);
    check("abort_done", calc_done == 1'b0, int'(calc_done), 0);
    reset_n = 1'b1;
    base = done_count;
    repeat (30) @(negedge clk);
    check("abort_no_done", done_count == base, done_count - base, 0);
    issue(1, 18'h0C000, 0, ref_val(1, 18'h0C000), 8, 1'b1);
    drain();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
